// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequential shift-add multiplier:
//     - FSM state encodings (plain 2-bit constants, legacy-compatible)
//     - cnt_width(): width of an iteration counter that can reach WIDTH
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold WIDTH itself, hence WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : mult_pkg

// File: rtl/seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_if
//   Operand/product handshake bundle for seq_multiplier.
//   Signals:
//     in_valid  upstream -> mult   operand pair valid
//     in_ready  mult -> upstream   block can accept operands
//     a, b      upstream -> mult   multiplicand / multiplier (WIDTH)
//     out_valid mult -> downstream product valid
//     out_ready downstream -> mult product accepted
//     product   mult -> downstream result (2*WIDTH), stable while out_valid
//   Modports: master = the side feeding operands and taking products,
//             slave  = the multiplier.
// -----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface : seq_multiplier_if

// File: rtl/mult_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mult_shift_add_dp
//   Datapath of the shift-add multiplier: multiplicand, multiplier, accumulator
//   and product registers plus the adder and (optionally) the sign fix-up.
//   Optional feature: SEQ_MULT_SIGNED_EN (two's complement operands).
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     i_load      latch operands, clear accumulator
//     i_step      perform one shift-add iteration
//     i_finish    capture final accumulator (incl. this cycle's add) as product
//     i_a, i_b    operands (sampled on i_load only)
//     o_product   registered result
// -----------------------------------------------------------------------------
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_finish,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_product
);

  // The multiplicand register is shifted left each step, so at iteration k it
  // holds mcand<<k without needing a barrel shifter.
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mplier;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
  logic r_sign;
  logic w_sign;

  // Magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH-1): the correct magnitude.
  assign w_a_mag  = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_b_mag  = i_b[WIDTH-1] ? -i_b : i_b;
  assign w_sign   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
  assign w_result = r_sign ? -w_acc_next : w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
    end else if (i_load) begin
      r_sign <= w_sign;
    end
  end
`else
  assign w_a_mag  = i_a;
  assign w_b_mag  = i_b;
  assign w_result = w_acc_next;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      if (i_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
      end else if (i_step) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      // Finish coincides with the last step, so the last add is folded in here.
      if (i_finish) begin
        r_product <= w_result;
      end
    end
  end

  assign o_product = r_product;

endmodule : mult_shift_add_dp

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier, one multiplier bit per clock, with
//   valid/ready handshakes on operands and product. Fixed latency: WIDTH BUSY
//   cycles regardless of operand values.
//   Optional feature: SEQ_MULT_SIGNED_EN (two's complement operands).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (release synchronously)
//     bus    seq_multiplier_if.slave: in_valid/in_ready/a/b,
//            out_valid/out_ready/product
// -----------------------------------------------------------------------------
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_step;
  logic             w_finish;

  // in_ready is a pure state decode, so reset drops it to 1 without a clock.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_step   = (r_state == ST_BUSY);
  assign w_finish = w_step && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_finish) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_finish  (w_finish),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_product (bus.product)
  );

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=16 instances).
//   Build with +define+SEQ_MULT_SIGNED_EN to exercise the signed variant.
//   Latency is counted with the accepting edge as edge 1, so out_valid is
//   expected to be seen right after edge WIDTH+1.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier_if #(.WIDTH(8))  bus8  ();
  seq_multiplier_if #(.WIDTH(16)) bus16 ();

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic on the operand values.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b);
    longint x;
    longint y;
    longint p;
    x = longint'(a);
    y = longint'(b);
`ifdef SEQ_MULT_SIGNED_EN
    if (a[w-1]) x = x - (longint'(1) << w);
    if (b[w-1]) y = y - (longint'(1) << w);
`endif
    p = x * y;
    return (w == 16) ? 32'(p) : (32'(p) & 32'h0000_FFFF);
  endfunction

  // Issue one job on the 8-bit DUT (must be idle) and wait for out_valid.
  task automatic job8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] prod, output int lat);
    bus8.a        = a;
    bus8.b        = b;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    lat = 1;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = bus8.product;
  endtask

  task automatic job16(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] prod, output int lat);
    bus16.a        = a;
    bus16.b        = b;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = bus16.product;
  endtask

  initial begin
    logic [15:0] p8;
    logic [31:0] p16;
    logic [15:0] held;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] ra16;
    logic [15:0] rb16;
    int          lat;
    int          viol;
    int          extra;

`ifdef SEQ_MULT_SIGNED_EN
    vecs[0] = '{8'hFB, 8'h0A, 16'hFFCE};   // -5 * 10
    vecs[1] = '{8'h80, 8'h80, 16'h4000};   // -128 * -128
    vecs[2] = '{8'h7F, 8'hFF, 16'hFF81};   // 127 * -1
    vecs[3] = '{8'hFF, 8'hFF, 16'h0001};   // -1 * -1
    vecs[4] = '{8'h00, 8'hC8, 16'h0000};   // 0 * -56
    vecs[5] = '{8'h05, 8'h0A, 16'h0032};   // 5 * 10
    vecs[6] = '{8'h80, 8'h01, 16'hFF80};   // -128 * 1
`else
    vecs[0] = '{8'd5,   8'd10,  16'd50};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd255, 8'd1,   16'd255};
`endif

    rst_n           = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_product",   32'(bus8.product),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, out_ready tied high
    for (int i = 0; i < 7; i++) begin
      job8(vecs[i].a, vecs[i].b, p8, lat);
      check($sformatf("vec%0d_product", i), 32'(p8), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle_ready", i), 32'(bus8.in_ready),  32'd1);
      check($sformatf("vec%0d_idle_valid", i), 32'(bus8.out_valid), 32'd0);
    end

    // in_valid pulse during BUSY is ignored
    bus8.a        = 8'd15;
    bus8.b        = 8'd15;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_ready", 32'(bus8.in_ready), 32'd0);
    bus8.a        = 8'd3;
    bus8.b        = 8'd4;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 4;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_product", 32'(bus8.product), 32'd225);
    check("ignore_latency", 32'(lat), 32'd9);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) extra++;
    end
    check("ignore_no_second_result", 32'(extra), 32'd0);

    // Back-pressure: hold DONE for 20 cycles
    bus8.out_ready = 1'b0;
    job8(8'd200, 8'd3, p8, lat);
    check("bp_product", 32'(p8), ref_mul(8, 16'd200, 16'd3));
    check("bp_latency", 32'(lat), 32'd9);
    held = p8;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus8.product !== held || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) viol++;
    end
    check("bp_stable", 32'(viol), 32'd0);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus8.in_ready),  32'd1);

    // Reset mid-BUSY aborts the job
    bus8.a        = 8'd7;
    bus8.b        = 8'd9;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus8.in_ready),  32'd1);
    check("abort_product",   32'(bus8.product),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    job8(8'd2, 8'd3, p8, lat);
    check("after_abort_product", 32'(p8), 32'd6);
    check("after_abort_latency", 32'(lat), 32'd9);
    @(posedge clk); #1;

    // Random 8-bit jobs against the reference model
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      job8(ra, rb, p8, lat);
      check($sformatf("rnd8_%0d_%0h_%0h", i, ra, rb), 32'(p8), ref_mul(8, 16'(ra), 16'(rb)));
      @(posedge clk); #1;
    end

    // Random 16-bit jobs, including the all-ones corner
    for (int i = 0; i < 20; i++) begin
      ra16 = (i == 0) ? 16'hFFFF : 16'($urandom);
      rb16 = (i == 0) ? 16'hFFFF : 16'($urandom);
      job16(ra16, rb16, p16, lat);
      check($sformatf("rnd16_%0d_%0h_%0h", i, ra16, rb16), p16, ref_mul(16, ra16, rb16));
      if (i == 0) check("rnd16_latency", 32'(lat), 32'd17);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_multiplier
